// File: rtl/fib_avalon_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fib_avalon_master                                                          |
// | Avalon-MM initiator: writes N and start to a Fibonacci slave, polls done, |
// | reads the result and returns it on a valid/ready response port.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fib_avalon_master #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_POLLS    = 1024,
  parameter int POLL_GAP     = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [31:0] c_lat_last  = 32'(READ_LATENCY - 1);
  localparam logic [31:0] c_gap_last  = 32'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [31:0] c_max_polls = 32'(MAX_POLLS);
  localparam logic        c_has_gap   = (POLL_GAP > 0);

  localparam logic [1:0] c_addr_n      = 2'd0;
  localparam logic [1:0] c_addr_ctrl   = 2'd1;
  localparam logic [1:0] c_addr_result = 2'd2;
  localparam logic [1:0] c_addr_status = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_N      = 4'd1,
    S_WR_GO     = 4'd2,
    S_RD_STAT   = 4'd3,
    S_WAIT_STAT = 4'd4,
    S_GAP       = 4'd5,
    S_RD_RES    = 4'd6,
    S_WAIT_RES  = 4'd7,
    S_RESP      = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_n;
  logic [31:0] r_polls;
  logic [31:0] r_cnt;
  logic [31:0] r_result;
  logic        r_timeout;
  logic        w_accept;
  logic        w_sample;
  logic        w_counting;
  logic        w_load;
  logic [31:0] w_result_next;
  logic        w_timeout_next;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_sample   = (r_cnt == c_lat_last);
  assign w_counting = (r_state == S_WAIT_STAT) || (r_state == S_WAIT_RES) ||
                      (r_state == S_GAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_polls   <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // r_cnt measures time spent in the current wait/gap state only
      if ((w_state_next != r_state) || !w_counting) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_accept) begin
        r_n     <= cmd_n;
        r_polls <= '0;
      end else if ((r_state == S_RD_STAT) && (r_polls != '1)) begin
        r_polls <= r_polls + 32'd1;
      end
      if (w_load) begin
        r_result  <= w_result_next;
        r_timeout <= w_timeout_next;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_result_next  = '0;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_next = S_WR_N;
        end
      end
      S_WR_N:    w_state_next = S_WR_GO;
      S_WR_GO:   w_state_next = S_RD_STAT;
      S_RD_STAT: w_state_next = S_WAIT_STAT;
      S_WAIT_STAT: begin
        if (w_sample) begin
          if (avm_readdata[0]) begin
            w_state_next = S_RD_RES;
          end else if (r_polls == c_max_polls) begin
            w_state_next   = S_RESP;
            w_load         = 1'b1;
            w_timeout_next = 1'b1;
          end else if (c_has_gap) begin
            w_state_next = S_GAP;
          end else begin
            w_state_next = S_RD_STAT;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_next = S_RD_STAT;
        end
      end
      S_RD_RES: w_state_next = S_WAIT_RES;
      S_WAIT_RES: begin
        if (w_sample) begin
          w_state_next  = S_RESP;
          w_load        = 1'b1;
          w_result_next = avm_readdata;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus signals decode straight from the async-reset state, so they drop with reset_n
  always_comb begin
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    case (r_state)
      S_WR_N: begin
        avm_write     = 1'b1;
        avm_address   = c_addr_n;
        avm_writedata = r_n;
      end
      S_WR_GO: begin
        avm_write     = 1'b1;
        avm_address   = c_addr_ctrl;
        avm_writedata = 32'h1;
      end
      S_RD_STAT: begin
        avm_read    = 1'b1;
        avm_address = c_addr_status;
      end
      S_RD_RES: begin
        avm_read    = 1'b1;
        avm_address = c_addr_result;
      end
      default: begin
        avm_read = 1'b0;
      end
    endcase
  end

  assign avm_chipselect = avm_read | avm_write;
  assign cmd_ready      = reset_n && (r_state == S_IDLE);
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_result     = r_result;
  assign rsp_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fib_avalon_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fib_avalon_master                                                       |
// | Directed bench: two master configurations, each with a register slave model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fib_avalon_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_n        [2];
  logic        cmd_valid      [2];
  logic        cmd_ready      [2];
  logic [31:0] cmd_n          [2];
  logic        rsp_valid      [2];
  logic        rsp_ready      [2];
  logic [31:0] rsp_result     [2];
  logic        rsp_timeout    [2];
  logic [1:0]  avm_address    [2];
  logic        avm_chipselect [2];
  logic        avm_read       [2];
  logic        avm_write      [2];
  logic [31:0] avm_writedata  [2];
  logic [31:0] avm_readdata   [2];

  int          done_after [2];
  logic        clr        [2];
  int          wr0_cnt    [2];
  int          wr1_cnt    [2];
  int          rd2_cnt    [2];
  int          rd3_cnt    [2];
  int          gap_err    [2];
  int          bus_err    [2];
  logic [31:0] wr0_data   [2];
  logic [31:0] wr1_data   [2];

  function automatic logic [31:0] fib(input logic [31:0] n);
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd1;
    logic [31:0] t;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Instance 0: READ_LATENCY=1, MAX_POLLS=8, POLL_GAP=0; instance 1: 3 / 1024 / 2
  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int RL      = (i == 0) ? 1 : 3;
    localparam int GAP     = (i == 0) ? 0 : 2;
    localparam int MP      = (i == 0) ? 8 : 1024;
    localparam int SPACING = 1 + RL + GAP;

    logic [31:0] pipe [0:3];
    logic [31:0] reg_n = '0;
    int stat_reads = 0;
    int last_rd3   = 0;
    int l_wr0 = 0, l_wr1 = 0, l_rd2 = 0, l_rd3 = 0, l_gap = 0, l_bus = 0;
    logic [31:0] l_wr0_data = '0, l_wr1_data = '0;

    fib_avalon_master #(
      .READ_LATENCY(RL),
      .MAX_POLLS   (MP),
      .POLL_GAP    (GAP)
    ) dut (
      .clk           (clk),
      .reset_n       (reset_n[i]),
      .cmd_valid     (cmd_valid[i]),
      .cmd_ready     (cmd_ready[i]),
      .cmd_n         (cmd_n[i]),
      .rsp_valid     (rsp_valid[i]),
      .rsp_ready     (rsp_ready[i]),
      .rsp_result    (rsp_result[i]),
      .rsp_timeout   (rsp_timeout[i]),
      .avm_address   (avm_address[i]),
      .avm_chipselect(avm_chipselect[i]),
      .avm_read      (avm_read[i]),
      .avm_write     (avm_write[i]),
      .avm_writedata (avm_writedata[i]),
      .avm_readdata  (avm_readdata[i])
    );

    assign avm_readdata[i] = pipe[RL-1];
    assign wr0_cnt[i]  = l_wr0;
    assign wr1_cnt[i]  = l_wr1;
    assign rd2_cnt[i]  = l_rd2;
    assign rd3_cnt[i]  = l_rd3;
    assign gap_err[i]  = l_gap;
    assign bus_err[i]  = l_bus;
    assign wr0_data[i] = l_wr0_data;
    assign wr1_data[i] = l_wr1_data;

    always @(posedge clk) begin
      for (int k = 3; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= 32'hA5A5_0000;
      l_bus <= l_bus
             + ((avm_read[i] && avm_write[i]) ? 1 : 0)
             + ((avm_chipselect[i] != (avm_read[i] | avm_write[i])) ? 1 : 0)
             + ((!avm_read[i] && !avm_write[i] &&
                 (avm_address[i] != 2'd0 || avm_writedata[i] != 32'd0)) ? 1 : 0);
      if (avm_write[i]) begin
        if (avm_address[i] == 2'd0) reg_n <= avm_writedata[i];
        if (avm_address[i] == 2'd1 && avm_writedata[i][0]) stat_reads <= 0;
      end
      if (avm_read[i]) begin
        if (avm_address[i] == 2'd3) begin
          stat_reads <= stat_reads + 1;
          pipe[0] <= {31'd0, (done_after[i] != 0 && stat_reads + 1 >= done_after[i])};
        end else if (avm_address[i] == 2'd2) begin
          pipe[0] <= fib(reg_n);
        end else begin
          pipe[0] <= 32'hDEAD_BEEF;
        end
      end
      if (clr[i]) begin
        l_wr0 <= 0; l_wr1 <= 0; l_rd2 <= 0; l_rd3 <= 0; l_gap <= 0;
        l_wr0_data <= '0; l_wr1_data <= '0;
      end else begin
        if (avm_write[i] && avm_address[i] == 2'd0) begin
          l_wr0 <= l_wr0 + 1;
          l_wr0_data <= avm_writedata[i];
        end
        if (avm_write[i] && avm_address[i] == 2'd1) begin
          l_wr1 <= l_wr1 + 1;
          l_wr1_data <= avm_writedata[i];
        end
        if (avm_read[i] && avm_address[i] == 2'd2) l_rd2 <= l_rd2 + 1;
        if (avm_read[i] && avm_address[i] == 2'd3) begin
          l_rd3 <= l_rd3 + 1;
          if (l_rd3 > 0 && (cyc - last_rd3) != SPACING) l_gap <= l_gap + 1;
          last_rd3 <= cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input int idx);
    @(posedge clk); #1 clr[idx] = 1'b1;
    @(posedge clk); #1 clr[idx] = 1'b0;
  endtask

  // Issue one command; lat is the cycle (accept = 0) in which rsp_valid first appears
  task automatic run_cmd(input int idx, input logic [31:0] n, input int stall,
                         output logic [31:0] res, output logic to, output int lat);
    clear_model(idx);
    check("idle_cmd_ready", 32'(cmd_ready[idx]), 32'd1);
    cmd_n[idx]     = n;
    cmd_valid[idx] = 1'b1;
    @(posedge clk); #1 cmd_valid[idx] = 1'b0;
    lat = 1;
    while (lat < 3000) begin
      @(negedge clk);
      if (rsp_valid[idx]) break;
      lat++;
    end
    if (!rsp_valid[idx]) check("rsp_wait_bound", 32'(rsp_valid[idx]), 32'd1);
    res = rsp_result[idx];
    to  = rsp_timeout[idx];
    for (int s = 0; s < stall; s++) begin
      cmd_valid[idx] = 1'b1;
      cmd_n[idx]     = 32'd99;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid[idx]), 32'd1);
      check("stall_result", rsp_result[idx], res);
      check("stall_timeout", 32'(rsp_timeout[idx]), 32'(to));
      check("stall_cmd_ready", 32'(cmd_ready[idx]), 32'd0);
    end
    cmd_valid[idx] = 1'b0;
    rsp_ready[idx] = 1'b1;
    check("hs_cmd_ready", 32'(cmd_ready[idx]), 32'd0);
    @(posedge clk); #1 rsp_ready[idx] = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", 32'(rsp_valid[idx]), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready[idx]), 32'd1);
  endtask

  logic [31:0] res;
  logic        to;
  int          lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_n[i] = '0;
      rsp_ready[i] = 1'b0; clr[i] = 1'b0; done_after[i] = 1;
    end
    #1;
    check("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_avm_cs", 32'(avm_chipselect[0]), 32'd0);
    check("rst_rsp_result", rsp_result[1], 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    #1 check("rel_cmd_ready", 32'(cmd_ready[0]), 32'd1);

    // N=21, done on the 5th poll
    done_after[0] = 5;
    run_cmd(0, 32'd21, 0, res, to, lat);
    check("n21_result", res, 32'd10946);
    check("n21_timeout", 32'(to), 32'd0);
    check("n21_latency", 32'(lat), 32'd15);
    check("n21_wr0_cnt", 32'(wr0_cnt[0]), 32'd1);
    check("n21_wr0_data", wr0_data[0], 32'd21);
    check("n21_wr1_cnt", 32'(wr1_cnt[0]), 32'd1);
    check("n21_wr1_data", wr1_data[0], 32'd1);
    check("n21_rd3_cnt", 32'(rd3_cnt[0]), 32'd5);
    check("n21_rd2_cnt", 32'(rd2_cnt[0]), 32'd1);
    check("n21_spacing", 32'(gap_err[0]), 32'd0);

    // N=0, done on first poll: response in cycle 7
    done_after[0] = 1;
    run_cmd(0, 32'd0, 0, res, to, lat);
    check("n0_result", res, 32'd0);
    check("n0_latency", 32'(lat), 32'd7);
    check("n0_rd3_cnt", 32'(rd3_cnt[0]), 32'd1);

    // N=7 with a 10-cycle response stall and an ignored command during it
    run_cmd(0, 32'd7, 10, res, to, lat);
    check("n7_result", res, 32'd13);
    check("n7_wr0_cnt", 32'(wr0_cnt[0]), 32'd1);
    check("n7_wr0_data", wr0_data[0], 32'd7);

    // Reset asserted while waiting on a status read
    done_after[0] = 0;
    clear_model(0);
    cmd_n[0] = 32'd5; cmd_valid[0] = 1'b1;
    @(posedge clk); #1 cmd_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_read", 32'(avm_read[0]), 32'd1);
    check("pre_rst_addr", 32'(avm_address[0]), 32'd3);
    @(negedge clk);
    check("pre_rst_result", rsp_result[0], 32'd13);
    reset_n[0] = 1'b0;
    #1;
    check("mid_rst_result", rsp_result[0], 32'd0);
    check("mid_rst_read", 32'(avm_read[0]), 32'd0);
    check("mid_rst_write", 32'(avm_write[0]), 32'd0);
    check("mid_rst_cs", 32'(avm_chipselect[0]), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n[0] = 1'b1;
    #1 check("post_rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    done_after[0] = 1;
    run_cmd(0, 32'd5, 0, res, to, lat);
    check("n5_result", res, 32'd5);
    check("n5_latency", 32'(lat), 32'd7);
    check("n5_wr0_data", wr0_data[0], 32'd5);

    // Slave never done: MAX_POLLS=8 status reads then timeout
    done_after[0] = 0;
    run_cmd(0, 32'd33, 0, res, to, lat);
    check("to_timeout", 32'(to), 32'd1);
    check("to_result", res, 32'd0);
    check("to_rd3_cnt", 32'(rd3_cnt[0]), 32'd8);
    check("to_rd2_cnt", 32'(rd2_cnt[0]), 32'd0);
    check("to_latency", 32'(lat), 32'd19);
    check("to_spacing", 32'(gap_err[0]), 32'd0);

    // READ_LATENCY=3, POLL_GAP=2, N=10, done on 3rd poll
    done_after[1] = 3;
    run_cmd(1, 32'd10, 0, res, to, lat);
    check("b_result", res, 32'd55);
    check("b_timeout", 32'(to), 32'd0);
    check("b_latency", 32'(lat), 32'd23);
    check("b_rd3_cnt", 32'(rd3_cnt[1]), 32'd3);
    check("b_rd2_cnt", 32'(rd2_cnt[1]), 32'd1);
    check("b_spacing", 32'(gap_err[1]), 32'd0);

    check("bus_rules_0", 32'(bus_err[0]), 32'd0);
    check("bus_rules_1", 32'(bus_err[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
